uart_dump_sequencer: RTL

UART_DUMP_SEQUENCER -- requirements
Module: uart_dump_sequencer

---
 rtl/uart_dump_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_dump_sequencer.sv
// Streams a window of 16-bit samples from a BRAM to a byte-wide UART transmitter, high byte first.
// Define DUMP_HEADER_EN to prefix every frame with SYNC_BYTE and the 16-bit sample count.
module uart_dump_sequencer #(
  parameter int unsigned BRAM_LATENCY = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_25mhz,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [15:0] start_index_in,
  input  logic [15:0] count_in,
  output logic [15:0] sample_addr_out,
  input  logic [15:0] sample_data_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        busy_out,
  output logic        done_out
);

  localparam int WAIT_W = (BRAM_LATENCY < 1) ? 1 : $clog2(BRAM_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BRAM_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef DUMP_HEADER_EN
    HEADER  = 3'd1,
`endif
    FETCH   = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       start_idx;
  logic [15:0]       start_idx_next;
  logic [15:0]       count;
  logic [15:0]       count_next;
  logic [15:0]       idx;
  logic [15:0]       idx_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic [15:0]       sample;
  logic [15:0]       sample_next;
  logic [15:0]       addr_next;
  logic [7:0]        byte_next;
  logic              valid_next;
  logic              busy_next;
  logic              done_next;
  logic              more_samples;
`ifdef DUMP_HEADER_EN
  logic [1:0]        hdr_cnt;
  logic [1:0]        hdr_next;
`endif

  // 17-bit compare so a 65535-sample frame ends cleanly without the index wrapping
  assign more_samples = (({1'b0, idx} + 17'd1) < {1'b0, count});

  // Next-state and next-output decode; every output is registered from these values
  always_comb begin
    state_next     = state;
    start_idx_next = start_idx;
    count_next     = count;
    idx_next       = idx;
    wait_next      = wait_cnt;
    sample_next    = sample;
    addr_next      = sample_addr_out;
    byte_next      = byte_out;
    valid_next     = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
`ifdef DUMP_HEADER_EN
    hdr_next       = hdr_cnt;
`endif
    case (state)
      IDLE: begin
        if (start_in) begin
          start_idx_next = start_index_in;
          count_next     = count_in;
          idx_next       = 16'd0;
`ifdef DUMP_HEADER_EN
          hdr_next       = 2'd0;
          byte_next      = SYNC_BYTE;
          state_next     = HEADER;
`else
          wait_next      = {WAIT_W{1'b0}};
          addr_next      = start_index_in;
          state_next     = FETCH;
`endif
        end else begin
          state_next = IDLE;
        end
      end
`ifdef DUMP_HEADER_EN
      HEADER: begin
        if (byte_ready_in) begin
          case (hdr_cnt)
            2'd0: begin
              hdr_next  = 2'd1;
              byte_next = count[15:8];
            end
            2'd1: begin
              hdr_next  = 2'd2;
              byte_next = count[7:0];
            end
            default: begin
              hdr_next = 2'd0;
              if (count == 16'd0) begin
                state_next = DONE;
              end else begin
                wait_next  = {WAIT_W{1'b0}};
                addr_next  = start_idx;
                state_next = FETCH;
              end
            end
          endcase
        end else begin
          state_next = HEADER;
        end
      end
`endif
      FETCH: begin
        if (count == 16'd0) begin
          state_next = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          sample_next = sample_data_in;
          byte_next   = sample_data_in[15:8];
          state_next  = SEND_HI;
        end else begin
          wait_next = wait_cnt + WAIT_ONE;
        end
      end
      SEND_HI: begin
        if (byte_ready_in) begin
          byte_next  = sample[7:0];
          state_next = SEND_LO;
        end else begin
          state_next = SEND_HI;
        end
      end
      SEND_LO: begin
        if (byte_ready_in) begin
          if (more_samples) begin
            idx_next   = idx + 16'd1;
            addr_next  = start_idx + idx + 16'd1;
            wait_next  = {WAIT_W{1'b0}};
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = SEND_LO;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
`ifdef DUMP_HEADER_EN
      HEADER:  valid_next = 1'b1;
`endif
      SEND_HI: valid_next = 1'b1;
      SEND_LO: valid_next = 1'b1;
      default: valid_next = 1'b0;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      state           <= IDLE;
      start_idx       <= 16'd0;
      count           <= 16'd0;
      idx             <= 16'd0;
      wait_cnt        <= {WAIT_W{1'b0}};
      sample          <= 16'd0;
      sample_addr_out <= 16'd0;
      byte_out        <= 8'd0;
      byte_valid_out  <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
`ifdef DUMP_HEADER_EN
      hdr_cnt         <= 2'd0;
`endif
    end else begin
      state           <= state_next;
      start_idx       <= start_idx_next;
      count           <= count_next;
      idx             <= idx_next;
      wait_cnt        <= wait_next;
      sample          <= sample_next;
      sample_addr_out <= addr_next;
      byte_out        <= byte_next;
      byte_valid_out  <= valid_next;
      busy_out        <= busy_next;
      done_out        <= done_next;
`ifdef DUMP_HEADER_EN
      hdr_cnt         <= hdr_next;
`endif
    end
  end

endmodule
